// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-serial memory arbiter.
// Lane tags, FSM encodings and the top-lane helper.
package mem_arbiter_pkg;

    localparam int SEL_W  = 4;
    localparam int EXT_DW = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] lane;
    } rd_tag_t;

    function automatic logic [1:0] top_lane(input logic [SEL_W-1:0] sel);
        logic [1:0] t;
        t = 2'd0;
        for (int k = 0; k < SEL_W; k++) begin
            if (sel[k]) t = 2'(k);
        end
        return t;
    endfunction

endpackage

// File: rtl/mem_lane_seq.sv
// Finds the lowest enabled lane at or above a start index,
// and flags whether it is the highest enabled lane.
module mem_lane_seq
    import mem_arbiter_pkg::*;
(
    input  logic [SEL_W-1:0] sel_i,
    input  logic [2:0]       from_i,
    output logic             found_o,
    output logic [1:0]       lane_o,
    output logic             last_o
);

    always_comb begin
        found_o = 1'b0;
        lane_o  = 2'd0;
        for (int k = SEL_W - 1; k >= 0; k--) begin
            if (sel_i[k] && (3'(k) >= from_i)) begin
                found_o = 1'b1;
                lane_o  = 2'(k);
            end
        end
        last_o = found_o && (lane_o == top_lane(sel_i));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM onto a byte-wide external port,
// sequencing enabled lanes and reassembling words little-endian.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [SEL_W-1:0]  mem_sel_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [31:0]       ext_addr_o,
    output logic [EXT_DW-1:0] ext_dout_o,
    input  logic [EXT_DW-1:0] ext_din_i,
    output logic              ext_wr_o,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o
);

    arb_state_t        state_q, state_d;
    gnt_t              gnt_q, gnt_d;
    gnt_t              last_grant_q, last_grant_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [1:0]        lane_q, lane_d;
    logic              issue_q, issue_d;
    logic              last_q, last_d;
    rd_tag_t           pipe_q [RD_LAT];
    rd_tag_t           pipe_d [RD_LAT];
    logic [31:0]       ext_addr_q, ext_addr_d;
    logic [EXT_DW-1:0] ext_dout_q, ext_dout_d;
    logic              ext_wr_q, ext_wr_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic              idle;
    logic              pick_mem;
    logic [SEL_W-1:0]  seq_sel;
    logic [2:0]        seq_from;
    logic              seq_found;
    logic [1:0]        seq_lane;
    logic              seq_last;
    logic [31:0]       src_addr;
    logic [31:0]       src_wdata;
    logic              src_we;
    rd_tag_t           cap;
    logic              fin;

    // On a collision the requester that was not served last wins.
    assign idle      = (state_q == ARB_IDLE);
    assign pick_mem  = mem_req_i & (~if_req_i | (last_grant_q == GNT_IF));
    assign seq_sel   = idle ? (pick_mem ? mem_sel_i : 4'hF) : sel_q;
    assign seq_from  = idle ? 3'd0 : ({1'b0, lane_q} + 3'd1);
    assign src_addr  = idle ? (pick_mem ? mem_addr_i : if_addr_i) : addr_q;
    assign src_wdata = idle ? mem_wdata_i : wdata_q;
    assign src_we    = idle ? (pick_mem & mem_we_i) : we_q;
    assign cap       = pipe_q[RD_LAT-1];

    mem_lane_seq u_seq (
        .sel_i   (seq_sel),
        .from_i  (seq_from),
        .found_o (seq_found),
        .lane_o  (seq_lane),
        .last_o  (seq_last)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        we_d         = we_q;
        sel_d        = sel_q;
        lane_d       = lane_q;
        issue_d      = issue_q;
        last_d       = last_q;
        pipe_d       = pipe_q;
        ext_addr_d   = ext_addr_q;
        ext_dout_d   = ext_dout_q;
        ext_wr_d     = ext_wr_q;
        if_done_d    = 1'b0;
        mem_done_d   = 1'b0;
        if_data_d    = if_data_q;
        mem_rdata_d  = mem_rdata_q;
        fin          = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                ext_wr_d = 1'b0;
                if (if_req_i || mem_req_i) begin
                    gnt_d        = pick_mem ? GNT_MEM : GNT_IF;
                    last_grant_d = pick_mem ? GNT_MEM : GNT_IF;
                    addr_d       = src_addr;
                    wdata_d      = src_wdata;
                    we_d         = src_we;
                    sel_d        = seq_sel;
                    rdata_d      = '0;
                    issue_d      = seq_found;
                    last_d       = seq_last;
                    state_d      = ARB_XFER;
                    if (seq_found) begin
                        lane_d     = seq_lane;
                        ext_addr_d = src_addr + {30'd0, seq_lane};
                        ext_dout_d = src_wdata[{seq_lane, 3'b000} +: 8];
                        ext_wr_d   = src_we;
                    end
                end
            end
            ARB_XFER: begin
                // Tag each read address so its byte lands RD_LAT cycles later.
                pipe_d[0] = '{valid: issue_q & ~we_q, lane: lane_q};
                for (int i = 1; i < RD_LAT; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
                if (cap.valid) begin
                    rdata_d[{cap.lane, 3'b000} +: 8] = ext_din_i;
                end
                if (issue_q && !last_q) begin
                    lane_d     = seq_lane;
                    last_d     = seq_last;
                    ext_addr_d = addr_q + {30'd0, seq_lane};
                    ext_dout_d = wdata_q[{seq_lane, 3'b000} +: 8];
                    ext_wr_d   = we_q;
                end else begin
                    issue_d  = 1'b0;
                    ext_wr_d = 1'b0;
                end
                fin = (sel_q == '0) ||
                      (we_q ? (issue_q && last_q)
                            : (cap.valid && (cap.lane == top_lane(sel_q))));
                if (fin) begin
                    state_d  = ARB_DONE;
                    ext_wr_d = 1'b0;
                    if (gnt_q == GNT_IF) begin
                        if_done_d = 1'b1;
                        if_data_d = rdata_d;
                    end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = rdata_d;
                    end
                end
            end
            ARB_DONE: begin
                ext_wr_d = 1'b0;
                state_d  = ARB_IDLE;
            end
            default: begin
                ext_wr_d = 1'b0;
                state_d  = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= GNT_IF;
            last_grant_q <= GNT_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            lane_q       <= '0;
            issue_q      <= 1'b0;
            last_q       <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            ext_addr_q   <= '0;
            ext_dout_q   <= '0;
            ext_wr_q     <= 1'b0;
            if_done_q    <= 1'b0;
            mem_done_q   <= 1'b0;
            if_data_q    <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            lane_q       <= lane_d;
            issue_q      <= issue_d;
            last_q       <= last_d;
            pipe_q       <= pipe_d;
            ext_addr_q   <= ext_addr_d;
            ext_dout_q   <= ext_dout_d;
            ext_wr_q     <= ext_wr_d;
            if_done_q    <= if_done_d;
            mem_done_q   <= mem_done_d;
            if_data_q    <= if_data_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign if_data_o      = if_data_q;
    assign if_done_o      = if_done_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign mem_done_o     = mem_done_q;
    assign ext_addr_o     = ext_addr_q;
    assign ext_dout_o     = ext_dout_q;
    assign ext_wr_o       = ext_wr_q;
    assign stallreq_if_o  = if_req_i & ~if_done_q;
    assign stallreq_mem_o = mem_req_i & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at RD_LAT=1 and RD_LAT=3,
// each instance backed by its own byte memory with matching read latency.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        init_mem;
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic [31:0] if_data   [2];
    logic        if_done   [2];
    logic        mem_req   [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_sel   [2];
    logic [31:0] mem_rdata [2];
    logic        mem_done  [2];
    logic [31:0] ext_addr  [2];
    logic [7:0]  ext_dout  [2];
    logic [7:0]  ext_din   [2];
    logic        ext_wr    [2];
    logic        stall_if  [2];
    logic        stall_mem [2];

    logic [7:0]  mem  [2][1024];
    logic [31:0] hist [2][3];
    int          wr_cnt [2];

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req[0]), .if_addr_i(if_addr[0]),
        .if_data_o(if_data[0]), .if_done_o(if_done[0]),
        .mem_req_i(mem_req[0]), .mem_we_i(mem_we[0]),
        .mem_addr_i(mem_addr[0]), .mem_wdata_i(mem_wdata[0]),
        .mem_sel_i(mem_sel[0]), .mem_rdata_o(mem_rdata[0]),
        .mem_done_o(mem_done[0]), .ext_addr_o(ext_addr[0]),
        .ext_dout_o(ext_dout[0]), .ext_din_i(ext_din[0]),
        .ext_wr_o(ext_wr[0]), .stallreq_if_o(stall_if[0]),
        .stallreq_mem_o(stall_mem[0])
    );

    mem_arbiter #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req[1]), .if_addr_i(if_addr[1]),
        .if_data_o(if_data[1]), .if_done_o(if_done[1]),
        .mem_req_i(mem_req[1]), .mem_we_i(mem_we[1]),
        .mem_addr_i(mem_addr[1]), .mem_wdata_i(mem_wdata[1]),
        .mem_sel_i(mem_sel[1]), .mem_rdata_o(mem_rdata[1]),
        .mem_done_o(mem_done[1]), .ext_addr_o(ext_addr[1]),
        .ext_dout_o(ext_dout[1]), .ext_din_i(ext_din[1]),
        .ext_wr_o(ext_wr[1]), .stallreq_if_o(stall_if[1]),
        .stallreq_mem_o(stall_mem[1])
    );

    // External RAMs: index 0 has 1-cycle read latency, index 1 has 3.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            hist[d][0] <= ext_addr[d];
            hist[d][1] <= hist[d][0];
            hist[d][2] <= hist[d][1];
            if (init_mem) begin
                for (int i = 0; i < 1024; i++) mem[d][i] <= 8'h00;
                mem[d][10'h100] <= 8'h11;
                mem[d][10'h101] <= 8'h22;
                mem[d][10'h102] <= 8'h33;
                mem[d][10'h103] <= 8'h44;
                mem[d][10'h000] <= 8'h5A;
                mem[d][10'h001] <= 8'hA5;
                mem[d][10'h3FE] <= 8'h5B;
                mem[d][10'h3FF] <= 8'hA6;
                wr_cnt[d] <= 0;
            end else if (ext_wr[d]) begin
                mem[d][ext_addr[d][9:0]] <= ext_dout[d];
                wr_cnt[d] <= wr_cnt[d] + 1;
            end
        end
    end

    assign ext_din[0] = mem[0][hist[0][0][9:0]];
    assign ext_din[1] = mem[1][hist[1][2][9:0]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts in IDLE at #1 after an edge (cycle 0); returns done cycle.
    task automatic run(input int d, input logic is_if, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel, output int cyc,
                       output logic [31:0] data, output logic extra_done);
        cyc  = -1;
        data = 32'hxxxx_xxxx;
        if (is_if) begin
            if_req[d]  = 1'b1;
            if_addr[d] = addr;
        end else begin
            mem_req[d]   = 1'b1;
            mem_we[d]    = we;
            mem_addr[d]  = addr;
            mem_wdata[d] = wdata;
            mem_sel[d]   = sel;
        end
        for (int c = 1; c <= 40 && cyc < 0; c++) begin
            @(posedge clk); #1;
            if (is_if ? if_done[d] : mem_done[d]) begin
                cyc  = c;
                data = is_if ? if_data[d] : mem_rdata[d];
            end
        end
        if_req[d]  = 1'b0;
        mem_req[d] = 1'b0;
        @(posedge clk); #1;
        extra_done = if_done[d] | mem_done[d];
    endtask

    typedef struct {
        string       name;
        logic        is_if;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          cyc;
        logic [31:0] data;
    } vec_t;

    vec_t        vecs [10];
    int          cyc, wr0, if_cyc, mem_cyc, stall_bad;
    logic [31:0] data;
    logic        extra;

    initial begin
        vecs[0] = '{"fetch100",   1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 6, 32'h4433_2211};
        vecs[1] = '{"st0101",     1'b0, 1'b1, 32'h200, 32'hAABB_CCDD, 4'b0101, 3, 32'h0};
        vecs[2] = '{"ld1100wrap", 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0, 4'b1100, 4, 32'hA55A_0000};
        vecs[3] = '{"st4",        1'b0, 1'b1, 32'h300, 32'h1234_5678, 4'hF, 5, 32'h0};
        vecs[4] = '{"st1",        1'b0, 1'b1, 32'h310, 32'hDEAD_BEEF, 4'b1000, 2, 32'h0};
        vecs[5] = '{"ld4",        1'b0, 1'b0, 32'h300, 32'h0, 4'hF, 6, 32'h1234_5678};
        vecs[6] = '{"ld1000",     1'b0, 1'b0, 32'h310, 32'h0, 4'b1000, 3, 32'hDE00_0000};
        vecs[7] = '{"ld1001",     1'b0, 1'b0, 32'h300, 32'h0, 4'b1001, 4, 32'h1200_0078};
        vecs[8] = '{"ldzero",     1'b0, 1'b0, 32'h300, 32'h0, 4'b0000, 2, 32'h0};
        vecs[9] = '{"ld0001",     1'b0, 1'b0, 32'h320, 32'h0, 4'b0001, 3, 32'h0000_0077};

        for (int d = 0; d < 2; d++) begin
            if_req[d] = 1'b0; if_addr[d] = '0;
            mem_req[d] = 1'b0; mem_we[d] = 1'b0; mem_addr[d] = '0;
            mem_wdata[d] = '0; mem_sel[d] = '0;
        end
        rst = 1'b0;
        init_mem = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        chk("rst_if_done",   32'(if_done[0]), 32'h0);
        chk("rst_mem_done",  32'(mem_done[0]), 32'h0);
        chk("rst_ext_wr",    32'(ext_wr[0]), 32'h0);
        chk("rst_ext_addr",  ext_addr[0], 32'h0);
        chk("rst_if_data",   if_data[0], 32'h0);
        chk("rst_mem_rdata", mem_rdata[1], 32'h0);
        rst = 1'b1;

        // Collision right after reset: MEM 1-byte store first, then IF.
        if_req[0] = 1'b1; if_addr[0] = 32'h100;
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 32'h320;
        mem_wdata[0] = 32'h0000_0077; mem_sel[0] = 4'b0001;
        #1;
        chk("col_stall_if0",  32'(stall_if[0]), 32'h1);
        chk("col_stall_mem0", 32'(stall_mem[0]), 32'h1);
        if_cyc = -1; mem_cyc = -1; stall_bad = 0;
        for (int c = 1; c <= 30 && if_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (mem_done[0]) begin
                mem_cyc = c;
                chk("col_stall_mem_done", 32'(stall_mem[0]), 32'h0);
                mem_req[0] = 1'b0;
            end
            if (if_done[0]) begin
                if_cyc = c;
                chk("col_if_data", if_data[0], 32'h4433_2211);
                if_req[0] = 1'b0;
            end else if (!stall_if[0]) begin
                stall_bad++;
            end
        end
        if_req[0] = 1'b0; mem_req[0] = 1'b0;
        @(posedge clk); #1;
        chk("col_mem_cycle", 32'(mem_cyc), 32'd2);
        chk("col_if_cycle",  32'(if_cyc), 32'd9);
        chk("col_stall_if_drop", 32'(stall_bad), 32'd0);
        chk("col_mem320", 32'(mem[0][10'h320]), 32'h77);

        for (int i = 0; i < 10; i++) begin
            wr0 = wr_cnt[0];
            run(0, vecs[i].is_if, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].sel, cyc, data, extra);
            chk({vecs[i].name, "_cycle"}, 32'(cyc), 32'(vecs[i].cyc));
            chk({vecs[i].name, "_data"}, data, vecs[i].data);
            chk({vecs[i].name, "_pulse"}, 32'(extra), 32'h0);
            chk({vecs[i].name, "_writes"}, 32'(wr_cnt[0] - wr0),
                vecs[i].we ? 32'($countones(vecs[i].sel)) : 32'h0);
        end
        chk("mem200", 32'(mem[0][10'h200]), 32'hDD);
        chk("mem201", 32'(mem[0][10'h201]), 32'h00);
        chk("mem202", 32'(mem[0][10'h202]), 32'hBB);
        chk("mem203", 32'(mem[0][10'h203]), 32'h00);
        chk("mem313", 32'(mem[0][10'h313]), 32'hDE);
        chk("mem310", 32'(mem[0][10'h310]), 32'h00);

        // Reset asserted while lane 2 of a 4-byte store is on the bus.
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 32'h400;
        mem_wdata[0] = 32'hCAFE_BABE; mem_sel[0] = 4'hF;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort_lane2_addr", ext_addr[0], 32'h402);
        chk("abort_lane2_wr",   32'(ext_wr[0]), 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ext_wr",   32'(ext_wr[0]), 32'h0);
        chk("abort_if_done",  32'(if_done[0]), 32'h0);
        chk("abort_mem_done", 32'(mem_done[0]), 32'h0);
        chk("abort_if_data",  if_data[0], 32'h0);
        mem_req[0] = 1'b0;
        rst = 1'b1;
        chk("abort_mem400", 32'(mem[0][10'h400]), 32'hBE);
        chk("abort_mem401", 32'(mem[0][10'h401]), 32'hBA);
        chk("abort_mem403", 32'(mem[0][10'h403]), 32'h00);
        run(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, cyc, data, extra);
        chk("abort_refetch_cycle", 32'(cyc), 32'd6);
        chk("abort_refetch_data",  data, 32'h4433_2211);

        // RD_LAT=3 instance.
        run(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, cyc, data, extra);
        chk("lat3_fetch_cycle", 32'(cyc), 32'd8);
        chk("lat3_fetch_data",  data, 32'h4433_2211);
        chk("lat3_fetch_pulse", 32'(extra), 32'h0);
        wr0 = wr_cnt[1];
        run(1, 1'b0, 1'b1, 32'h500, 32'h1111_1111, 4'b0000, cyc, data, extra);
        chk("lat3_zero_cycle",  32'(cyc), 32'd2);
        chk("lat3_zero_data",   data, 32'h0);
        chk("lat3_zero_writes", 32'(wr_cnt[1] - wr0), 32'h0);
        chk("lat3_zero_addr",   ext_addr[1], 32'h103);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
